// File: rtl/qpsk_pkg.sv
// Shared types and word geometry for the QPSK receive path.
package qpsk_pkg;
   localparam int SYMS_PER_WORD = 11;
   localparam int DATA_W        = 21;
   localparam int BUF_W         = 2 * (SYMS_PER_WORD - 1);

   typedef logic [1:0] qpsk_sym_t;

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} demod_state_t;
endpackage

// File: rtl/qpsk_slicer.sv
// Hard-decision QPSK slicer: {b1, b0} = {Q < 0, I < 0}, zero decides positive.
// Purely combinational; no flow control.
module qpsk_slicer
   import qpsk_pkg::*;
#(
   parameter int SAMPLE_W = 12
) (
   input  logic [SAMPLE_W-1:0] i_i,
   input  logic [SAMPLE_W-1:0] i_q,
   output qpsk_sym_t           o_sym
);

   localparam logic signed [SAMPLE_W-1:0] ZERO = '0;

   assign o_sym = {($signed(i_q) < ZERO), ($signed(i_i) < ZERO)};

endmodule

// File: rtl/qpsk_demodulator.sv
// QPSK hard demodulator: 11 symbols -> 21-bit word, m_valid one cycle after the 11th sample;
// s_ready drops while a word is held unaccepted. Optional pad check: QPSK_DEMOD_PAD_CHECK_EN.
module qpsk_demodulator
   import qpsk_pkg::*;
#(
   parameter int SAMPLE_W = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                s_first,
   input  logic [SAMPLE_W-1:0] s_i,
   input  logic [SAMPLE_W-1:0] s_q,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [DATA_W-1:0]   m_data,
   output logic [7:0]          drop_cnt
`ifdef QPSK_DEMOD_PAD_CHECK_EN
   ,
   output logic                pad_err
`endif
);

   localparam logic [3:0] LAST_CNT = 4'(SYMS_PER_WORD - 1);

   demod_state_t      r_state;
   demod_state_t      w_next_state;
   logic [3:0]        r_sym_cnt;
   logic [BUF_W-1:0]  r_buf;
   logic [DATA_W-1:0] r_m_data;
   logic              r_m_valid;
   logic              r_s_ready;
   logic [7:0]        r_drop_cnt;
   qpsk_sym_t         w_sym;
   logic              w_xfer;
   logic              w_word_xfer;
   logic              w_start;
   logic              w_store;
   logic              w_done;
   logic              w_drop;

   qpsk_slicer #(.SAMPLE_W(SAMPLE_W)) u_slicer (
      .i_i   (s_i),
      .i_q   (s_q),
      .o_sym (w_sym)
   );

   assign w_xfer      = s_valid & r_s_ready;
   assign w_word_xfer = r_m_valid & m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_xfer && s_first) w_next_state = COLLECT;
         end
         COLLECT: begin
            if (w_xfer && !s_first && r_sym_cnt == LAST_CNT) w_next_state = HOLD;
         end
         HOLD: begin
            if (w_word_xfer) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // A framed sample in COLLECT restarts the word, including on the 11th position.
   always_comb begin
      w_start = 1'b0;
      w_store = 1'b0;
      w_done  = 1'b0;
      w_drop  = 1'b0;
      case (r_state)
         IDLE: begin
            w_start = w_xfer & s_first;
         end
         COLLECT: begin
            if (w_xfer) begin
               if (s_first) begin
                  w_start = 1'b1;
                  w_drop  = 1'b1;
               end else begin
                  w_store = 1'b1;
                  w_done  = (r_sym_cnt == LAST_CNT);
               end
            end
         end
         default: ;
      endcase
   end

   // r_buf keeps symbols 0..9; symbol 10 goes straight into m_data and its b0 is the pad.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_ready  <= 1'b0;
         r_sym_cnt  <= '0;
         r_buf      <= '0;
         r_m_data   <= '0;
         r_m_valid  <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_s_ready <= (w_next_state != HOLD);
         if (w_start) begin
            r_buf     <= {{(BUF_W-2){1'b0}}, w_sym};
            r_sym_cnt <= 4'd1;
         end else if (w_store) begin
            r_buf     <= {r_buf[BUF_W-3:0], w_sym};
            r_sym_cnt <= r_sym_cnt + 4'd1;
         end else if (w_word_xfer) begin
            r_sym_cnt <= '0;
         end
         if (w_done) begin
            r_m_data  <= {r_buf, w_sym[1]};
            r_m_valid <= 1'b1;
         end else if (w_word_xfer) begin
            r_m_valid <= 1'b0;
         end
         if (w_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

`ifdef QPSK_DEMOD_PAD_CHECK_EN
   logic r_pad_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pad_err <= 1'b0;
      end else if (w_done) begin
         r_pad_err <= w_sym[0];
      end else if (w_word_xfer) begin
         r_pad_err <= 1'b0;
      end
   end

   assign pad_err = r_pad_err;
`endif

   assign s_ready  = r_s_ready;
   assign m_valid  = r_m_valid;
   assign m_data   = r_m_data;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Directed self-checking bench for qpsk_demodulator (pad checks active with QPSK_DEMOD_PAD_CHECK_EN).
module tb_qpsk_demodulator;

   localparam logic [11:0] POS = 12'd1000;
   localparam logic [11:0] NEG = 12'hC18;   // -1000

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic        s_first;
   logic [11:0] s_i;
   logic [11:0] s_q;
   logic        m_valid;
   logic        m_ready;
   logic [20:0] m_data;
   logic [7:0]  drop_cnt;
`ifdef QPSK_DEMOD_PAD_CHECK_EN
   logic        pad_err;
`endif

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   qpsk_demodulator #(.SAMPLE_W(12)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_first  (s_first),
      .s_i      (s_i),
      .s_q      (s_q),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .drop_cnt (drop_cnt)
`ifdef QPSK_DEMOD_PAD_CHECK_EN
      ,
      .pad_err  (pad_err)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Modulator model: symbol k carries {d, pad}[21-2k : 20-2k] as {b1 -> Q, b0 -> I}.
   task automatic send_syms(input logic [20:0] d, input logic pad, input int k0, input int k1);
      logic [21:0] w;
      w = {d, pad};
      for (int k = k0; k <= k1; k++) begin
         s_valid = 1'b1;
         s_first = (k == 0);
         s_i     = w[20-2*k] ? NEG : POS;
         s_q     = w[21-2*k] ? NEG : POS;
         tick();
      end
      s_valid = 1'b0;
      s_first = 1'b0;
   endtask

   task automatic send_const(input logic [11:0] iv, input logic [11:0] qv);
      for (int k = 0; k < 11; k++) begin
         s_valid = 1'b1;
         s_first = (k == 0);
         s_i     = iv;
         s_q     = qv;
         tick();
      end
      s_valid = 1'b0;
      s_first = 1'b0;
   endtask

   task automatic accept();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; s_first = 1'b0; s_i = '0; s_q = '0; m_ready = 1'b0;
      #12;
      n_chk++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %b want 0", s_ready); else n_pass++;
      n_chk++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b want 0", m_valid); else n_pass++;
      n_chk++; if (m_data !== 21'h0) $display("FAIL rst_m_data got %h want 0", m_data); else n_pass++;
      n_chk++; if (drop_cnt !== 8'd0) $display("FAIL rst_drop got %0d want 0", drop_cnt); else n_pass++;
`ifdef QPSK_DEMOD_PAD_CHECK_EN
      n_chk++; if (pad_err !== 1'b0) $display("FAIL rst_pad_err got %b want 0", pad_err); else n_pass++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_chk++; if (s_ready !== 1'b1) $display("FAIL rel_s_ready got %b want 1", s_ready); else n_pass++;
   endtask

   task automatic test_ideal();
      m_ready = 1'b1;
      send_syms(21'h155555, 1'b0, 0, 9);
      n_chk++; if (m_valid !== 1'b0) $display("FAIL ideal_early_valid got %b want 0", m_valid); else n_pass++;
      send_syms(21'h155555, 1'b0, 10, 10);
      n_chk++; if (m_valid !== 1'b1) $display("FAIL ideal_valid got %b want 1", m_valid); else n_pass++;
      n_chk++; if (m_data !== 21'h155555) $display("FAIL ideal_data got %h want 155555", m_data); else n_pass++;
      n_chk++; if (s_ready !== 1'b0) $display("FAIL ideal_hold_ready got %b want 0", s_ready); else n_pass++;
`ifdef QPSK_DEMOD_PAD_CHECK_EN
      n_chk++; if (pad_err !== 1'b0) $display("FAIL ideal_pad_err got %b want 0", pad_err); else n_pass++;
`endif
      tick();
      m_ready = 1'b0;
      n_chk++; if (m_valid !== 1'b0) $display("FAIL ideal_after_valid got %b want 0", m_valid); else n_pass++;
      n_chk++; if (s_ready !== 1'b1) $display("FAIL ideal_after_ready got %b want 1", s_ready); else n_pass++;
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      send_syms(21'h0ABCDE, 1'b0, 0, 10);
      for (int c = 0; c < 5; c++) begin
         n_chk++; if (m_valid !== 1'b1) $display("FAIL bp_valid c%0d got %b want 1", c, m_valid); else n_pass++;
         n_chk++; if (s_ready !== 1'b0) $display("FAIL bp_ready c%0d got %b want 0", c, s_ready); else n_pass++;
         n_chk++; if (m_data !== 21'h0ABCDE) $display("FAIL bp_data c%0d got %h want 0abcde", c, m_data); else n_pass++;
         s_valid = 1'b1; s_first = 1'b1; s_i = NEG; s_q = NEG;
         tick();
      end
      s_valid = 1'b0; s_first = 1'b0;
      n_chk++; if (drop_cnt !== 8'd0) $display("FAIL bp_drop got %0d want 0", drop_cnt); else n_pass++;
      accept();
      n_chk++; if (m_valid !== 1'b0) $display("FAIL bp_after_valid got %b want 0", m_valid); else n_pass++;
      n_chk++; if (s_ready !== 1'b1) $display("FAIL bp_after_ready got %b want 1", s_ready); else n_pass++;
   endtask

   task automatic test_boundary();
      send_const(12'h000, 12'h000);
      n_chk++; if (m_valid !== 1'b1) $display("FAIL zero_valid got %b want 1", m_valid); else n_pass++;
      n_chk++; if (m_data !== 21'h000000) $display("FAIL zero_data got %h want 000000", m_data); else n_pass++;
      accept();
      send_const(12'h800, 12'h800);
      n_chk++; if (m_data !== 21'h1FFFFF) $display("FAIL min_data got %h want 1fffff", m_data); else n_pass++;
`ifdef QPSK_DEMOD_PAD_CHECK_EN
      n_chk++; if (pad_err !== 1'b1) $display("FAIL min_pad_err got %b want 1", pad_err); else n_pass++;
`endif
      accept();
`ifdef QPSK_DEMOD_PAD_CHECK_EN
      n_chk++; if (pad_err !== 1'b0) $display("FAIL pad_err_clear got %b want 0", pad_err); else n_pass++;
`endif
   endtask

   task automatic test_idle_junk();
      for (int k = 0; k < 4; k++) begin
         s_valid = 1'b1; s_first = 1'b0; s_i = NEG; s_q = POS;
         tick();
         n_chk++; if (m_valid !== 1'b0) $display("FAIL junk_valid k%0d got %b want 0", k, m_valid); else n_pass++;
      end
      s_valid = 1'b0;
      n_chk++; if (drop_cnt !== 8'd0) $display("FAIL junk_drop got %0d want 0", drop_cnt); else n_pass++;
      send_syms(21'h1C3A5F, 1'b0, 0, 10);
      n_chk++; if (m_data !== 21'h1C3A5F) $display("FAIL junk_next_data got %h want 1c3a5f", m_data); else n_pass++;
      accept();
   endtask

   task automatic test_resync();
      send_syms(21'h0F0F0F, 1'b0, 0, 5);
      send_syms(21'h12345A, 1'b0, 0, 10);
      n_chk++; if (drop_cnt !== 8'd1) $display("FAIL resync_drop got %0d want 1", drop_cnt); else n_pass++;
      n_chk++; if (m_data !== 21'h12345A) $display("FAIL resync_data got %h want 12345a", m_data); else n_pass++;
      accept();
      send_syms(21'h0F0F0F, 1'b0, 0, 9);
      send_syms(21'h0DEAD1, 1'b0, 0, 0);
      n_chk++; if (m_valid !== 1'b0) $display("FAIL first11_valid got %b want 0", m_valid); else n_pass++;
      n_chk++; if (drop_cnt !== 8'd2) $display("FAIL first11_drop got %0d want 2", drop_cnt); else n_pass++;
      send_syms(21'h0DEAD1, 1'b0, 1, 10);
      n_chk++; if (m_data !== 21'h0DEAD1) $display("FAIL first11_data got %h want 0dead1", m_data); else n_pass++;
      accept();
      for (int r = 0; r < 298; r++) begin
         send_syms(21'h0F0F0F, 1'b0, 0, 5);
         send_syms(21'h0A5A5A, 1'b0, 0, 10);
         accept();
      end
      n_chk++; if (drop_cnt !== 8'd255) $display("FAIL sat_drop got %0d want 255", drop_cnt); else n_pass++;
      send_syms(21'h0F0F0F, 1'b0, 0, 5);
      send_syms(21'h0A5A5A, 1'b0, 0, 10);
      n_chk++; if (drop_cnt !== 8'd255) $display("FAIL sat_hold got %0d want 255", drop_cnt); else n_pass++;
      n_chk++; if (m_data !== 21'h0A5A5A) $display("FAIL sat_data got %h want 0a5a5a", m_data); else n_pass++;
      accept();
   endtask

   task automatic test_reset_midop();
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send_syms(21'h155555, 1'b0, 0, 4);
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (s_ready !== 1'b0) $display("FAIL mid_s_ready got %b want 0", s_ready); else n_pass++;
      n_chk++; if (drop_cnt !== 8'd0) $display("FAIL mid_drop got %0d want 0", drop_cnt); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      m_ready = 1'b0;
      send_syms(21'h1ABCDE, 1'b0, 0, 10);
      n_chk++; if (m_valid !== 1'b1) $display("FAIL hold_pre_valid got %b want 1", m_valid); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (m_valid !== 1'b0) $display("FAIL hold_rst_valid got %b want 0", m_valid); else n_pass++;
      n_chk++; if (m_data !== 21'h0) $display("FAIL hold_rst_data got %h want 0", m_data); else n_pass++;
      n_chk++; if (s_ready !== 1'b0) $display("FAIL hold_rst_ready got %b want 0", s_ready); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send_syms(21'h0C0FFE, 1'b0, 0, 10);
      n_chk++; if (m_data !== 21'h0C0FFE) $display("FAIL post_rst_data got %h want 0c0ffe", m_data); else n_pass++;
      n_chk++; if (drop_cnt !== 8'd0) $display("FAIL post_rst_drop got %0d want 0", drop_cnt); else n_pass++;
      accept();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ideal();
      test_backpressure();
      test_boundary();
      test_idle_junk();
      test_resync();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
